// File: rtl/ref_pix_axi_rd_slave.sv
// AXI4 read-only responder serving INCR bursts from a 1-cycle-latency block RAM.
// Queues AR requests, throttles issue by R-buffer credit, and returns SLVERR for illegal requests.
module ref_pix_axi_rd_slave #(
  parameter int unsigned               AXI_ADDR_WDTH       = 32,
  parameter int unsigned               AXI_CACHE_DATA_WDTH = 512,
  parameter int unsigned               MEM_ADDR_WDTH       = 16,
  parameter logic [AXI_ADDR_WDTH-1:0]  MEM_BASE_ADDR       = '0,
  parameter int unsigned               AR_FIFO_DEPTH       = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [AXI_ADDR_WDTH-1:0]       ref_pix_axi_ar_addr,
  input  logic [7:0]                     ref_pix_axi_ar_len,
  input  logic [2:0]                     ref_pix_axi_ar_size,
  input  logic [1:0]                     ref_pix_axi_ar_burst,
  input  logic [2:0]                     ref_pix_axi_ar_prot,
  input  logic                           ref_pix_axi_ar_valid,
  output logic                           ref_pix_axi_ar_ready,
  output logic [AXI_CACHE_DATA_WDTH-1:0] ref_pix_axi_r_data,
  output logic [1:0]                     ref_pix_axi_r_resp,
  output logic                           ref_pix_axi_r_last,
  output logic                           ref_pix_axi_r_valid,
  input  logic                           ref_pix_axi_r_ready,
  output logic                           mem_rd_en_out,
  output logic [MEM_ADDR_WDTH-1:0]       mem_rd_addr_out,
  input  logic [AXI_CACHE_DATA_WDTH-1:0] mem_rd_data_in,
  output logic                           rd_slave_idle_out
);

  localparam int unsigned DATA_BYTES = AXI_CACHE_DATA_WDTH / 8;
  localparam int unsigned SIZE_LOG2  = $clog2(DATA_BYTES);
  localparam int unsigned FAW        = $clog2(AR_FIFO_DEPTH);
  localparam int unsigned EW         = AXI_ADDR_WDTH + 2;

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } state_e;

  logic unused_prot;
  assign unused_prot = ^ref_pix_axi_ar_prot;

  // ---------------- request decode ----------------
  logic [AXI_ADDR_WDTH:0]     off_ext;
  logic [AXI_ADDR_WDTH-1:0]   off;
  logic [EW-1:0]              end_idx;
  logic [MEM_ADDR_WDTH-1:0]   req_idx;
  logic                       req_err;

  always_comb begin
    // Extra MSB of the subtraction is the borrow: address below the memory window.
    off_ext = {1'b0, ref_pix_axi_ar_addr} - {1'b0, MEM_BASE_ADDR};
    off     = off_ext[AXI_ADDR_WDTH-1:0];
    req_idx = MEM_ADDR_WDTH'(off >> SIZE_LOG2);
    end_idx = EW'(off >> SIZE_LOG2) + EW'(ref_pix_axi_ar_len);
    req_err = off_ext[AXI_ADDR_WDTH]
            | (ref_pix_axi_ar_burst != 2'b01)
            | (ref_pix_axi_ar_size != 3'(SIZE_LOG2))
            | ((end_idx >> MEM_ADDR_WDTH) != '0);
  end

  // ---------------- AR FIFO ----------------
  logic [MEM_ADDR_WDTH-1:0] fifo_idx_q [AR_FIFO_DEPTH];
  logic [7:0]               fifo_len_q [AR_FIFO_DEPTH];
  logic                     fifo_err_q [AR_FIFO_DEPTH];
  logic [FAW:0]             fifo_wr_q, fifo_rd_q;
  logic                     fifo_empty, fifo_full;
  logic                     ar_push, ar_pop;

  assign fifo_empty = (fifo_wr_q == fifo_rd_q);
  assign fifo_full  = (fifo_wr_q[FAW] != fifo_rd_q[FAW]) &&
                      (fifo_wr_q[FAW-1:0] == fifo_rd_q[FAW-1:0]);

  assign ref_pix_axi_ar_ready = !fifo_full && !reset;
  assign ar_push              = ref_pix_axi_ar_valid && ref_pix_axi_ar_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_wr_q <= '0;
      fifo_rd_q <= '0;
      for (int unsigned i = 0; i < AR_FIFO_DEPTH; i++) begin
        fifo_idx_q[i] <= '0;
        fifo_len_q[i] <= '0;
        fifo_err_q[i] <= 1'b0;
      end
    end else begin
      if (ar_push) begin
        fifo_idx_q[fifo_wr_q[FAW-1:0]] <= req_idx;
        fifo_len_q[fifo_wr_q[FAW-1:0]] <= ref_pix_axi_ar_len;
        fifo_err_q[fifo_wr_q[FAW-1:0]] <= req_err;
        fifo_wr_q <= fifo_wr_q + (FAW+1)'(1);
      end
      if (ar_pop) begin
        fifo_rd_q <= fifo_rd_q + (FAW+1)'(1);
      end
    end
  end

  // ---------------- output skid buffer ----------------
  logic [AXI_CACHE_DATA_WDTH-1:0] buf_data_q [2];
  logic [1:0]                     buf_resp_q [2];
  logic                           buf_last_q [2];
  logic                           buf_wr_q, buf_rd_q;
  logic [1:0]                     occ_q;
  logic                           r_pop;

  logic pend_v_q, pend_last_q, pend_err_q;

  assign ref_pix_axi_r_valid = (occ_q != 2'd0);
  assign r_pop               = ref_pix_axi_r_valid && ref_pix_axi_r_ready;
  assign ref_pix_axi_r_data  = ref_pix_axi_r_valid ? buf_data_q[buf_rd_q] : '0;
  assign ref_pix_axi_r_resp  = ref_pix_axi_r_valid ? buf_resp_q[buf_rd_q] : 2'b00;
  assign ref_pix_axi_r_last  = ref_pix_axi_r_valid && buf_last_q[buf_rd_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_wr_q <= 1'b0;
      buf_rd_q <= 1'b0;
      occ_q    <= 2'd0;
      for (int unsigned i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
        buf_resp_q[i] <= 2'b00;
        buf_last_q[i] <= 1'b0;
      end
    end else begin
      if (pend_v_q) begin
        buf_data_q[buf_wr_q] <= pend_err_q ? '0 : mem_rd_data_in;
        buf_resp_q[buf_wr_q] <= pend_err_q ? 2'b10 : 2'b00;
        buf_last_q[buf_wr_q] <= pend_last_q;
        buf_wr_q             <= ~buf_wr_q;
      end
      if (r_pop) begin
        buf_rd_q <= ~buf_rd_q;
      end
      occ_q <= occ_q + 2'(pend_v_q) - 2'(r_pop);
    end
  end

  // ---------------- burst FSM ----------------
  state_e                   state_q, state_d;
  logic [MEM_ADDR_WDTH-1:0] ptr_q, ptr_d;
  logic [7:0]               cnt_q, cnt_d;
  logic                     err_q, err_d;
  logic                     issue;
  logic [2:0]               credit;

  // A beat popped this cycle frees its slot in time, which sustains 1 beat/cycle.
  assign credit = 3'(occ_q) + 3'(pend_v_q) - 3'(r_pop);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ar_pop  = 1'b0;
    issue   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !reset) begin
          ar_pop  = 1'b1;
          ptr_d   = fifo_idx_q[fifo_rd_q[FAW-1:0]];
          cnt_d   = fifo_len_q[fifo_rd_q[FAW-1:0]];
          err_d   = fifo_err_q[fifo_rd_q[FAW-1:0]];
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        if ((credit < 3'd2) && !reset) begin
          issue = 1'b1;
          ptr_d = ptr_q + MEM_ADDR_WDTH'(1);
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd0) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      pend_v_q    <= 1'b0;
      pend_last_q <= 1'b0;
      pend_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      pend_v_q    <= issue;
      pend_last_q <= issue && (cnt_q == 8'd0);
      pend_err_q  <= err_q;
    end
  end

  assign mem_rd_en_out     = issue && !err_q;
  assign mem_rd_addr_out   = mem_rd_en_out ? ptr_q : '0;
  assign rd_slave_idle_out = fifo_empty && (state_q == ST_IDLE) &&
                             (occ_q == 2'd0) && !pend_v_q;

endmodule

// File: tb/tb_ref_pix_axi_rd_slave.sv
// Directed self-checking bench for ref_pix_axi_rd_slave with a behavioural 1-cycle RAM.
module tb_ref_pix_axi_rd_slave;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  ar_addr;
  logic [7:0]   ar_len;
  logic [2:0]   ar_size;
  logic [1:0]   ar_burst;
  logic [2:0]   ar_prot;
  logic         ar_valid;
  logic         ar_ready;
  logic [511:0] r_data;
  logic [1:0]   r_resp;
  logic         r_last;
  logic         r_valid;
  logic         r_ready;
  logic         mem_rd_en_out;
  logic [15:0]  mem_rd_addr_out;
  logic [511:0] mem_q;
  logic         idle;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ref_pix_axi_rd_slave #(
    .AXI_ADDR_WDTH(32),
    .AXI_CACHE_DATA_WDTH(512),
    .MEM_ADDR_WDTH(16),
    .MEM_BASE_ADDR(32'h0),
    .AR_FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ref_pix_axi_ar_addr(ar_addr),
    .ref_pix_axi_ar_len(ar_len),
    .ref_pix_axi_ar_size(ar_size),
    .ref_pix_axi_ar_burst(ar_burst),
    .ref_pix_axi_ar_prot(ar_prot),
    .ref_pix_axi_ar_valid(ar_valid),
    .ref_pix_axi_ar_ready(ar_ready),
    .ref_pix_axi_r_data(r_data),
    .ref_pix_axi_r_resp(r_resp),
    .ref_pix_axi_r_last(r_last),
    .ref_pix_axi_r_valid(r_valid),
    .ref_pix_axi_r_ready(r_ready),
    .mem_rd_en_out(mem_rd_en_out),
    .mem_rd_addr_out(mem_rd_addr_out),
    .mem_rd_data_in(mem_q),
    .rd_slave_idle_out(idle)
  );

  function automatic logic [511:0] pat(input logic [15:0] a);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = {a, 8'(i), 8'hA5};
    return r;
  endfunction

  // Memory model and R-channel collector.
  logic [511:0] rx_data[$];
  logic [1:0]   rx_resp[$];
  logic         rx_last[$];
  int           mem_en_cnt = 0;
  int           stall_err  = 0;
  logic         prev_stall = 1'b0;
  logic [511:0] prev_data;
  logic [1:0]   prev_resp;
  logic         prev_last;

  always @(posedge clk) begin
    if (mem_rd_en_out) begin
      mem_q <= pat(mem_rd_addr_out);
      mem_en_cnt++;
    end
    if (prev_stall && (!r_valid || r_data !== prev_data || r_resp !== prev_resp || r_last !== prev_last))
      stall_err++;
    prev_stall = r_valid && !r_ready && !reset;
    prev_data  = r_data;
    prev_resp  = r_resp;
    prev_last  = r_last;
    if (r_valid && r_ready) begin
      rx_data.push_back(r_data);
      rx_resp.push_back(r_resp);
      rx_last.push_back(r_last);
    end
  end

  task automatic clear_rx();
    rx_data.delete();
    rx_resp.delete();
    rx_last.delete();
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send_ar(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b,
                         input logic [2:0] s, output bit ok);
    ar_addr = a; ar_len = l; ar_burst = b; ar_size = s; ar_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (ar_ready) ok = 1'b1;
      @(negedge clk);
      if (ok) break;
    end
    ar_valid = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rx_data.size() >= n) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (rx_data.size() >= n) ok = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; ar_valid = 1'b0; ar_addr = '0; ar_len = '0; ar_size = 3'd6;
    ar_burst = 2'b01; ar_prot = 3'b000; r_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (ar_ready !== 1'b0) begin bad++; $display("FAIL reset_ar_ready_in_reset got=%0b exp=0", ar_ready); end
    reset = 1'b0;
    @(negedge clk);
    total++; if (ar_ready !== 1'b1) begin bad++; $display("FAIL reset_ar_ready got=%0b exp=1", ar_ready); end
    total++; if ({r_valid, r_last, r_resp} !== 4'b0) begin bad++; $display("FAIL reset_r_ctrl got=%b exp=0000", {r_valid, r_last, r_resp}); end
    total++; if (r_data !== '0) begin bad++; $display("FAIL reset_r_data got=%h exp=0", r_data); end
    total++; if ({mem_rd_en_out, mem_rd_addr_out} !== 17'd0) begin bad++; $display("FAIL reset_mem got=%h exp=0", {mem_rd_en_out, mem_rd_addr_out}); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%0b exp=1", idle); end
  endtask

  task automatic test_basic();
    bit ok; int k;
    clear_rx(); r_ready = 1'b1;
    send_ar(32'h0, 8'd3, 2'b01, 3'd6, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_ar_accept got=0 exp=1"); end
    k = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); k++;
      if (r_valid) break;
    end
    total++; if (k !== 3) begin bad++; $display("FAIL basic_latency got=%0d exp=3", k); end
    wait_beats(4, 50, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_timeout got=%0d beats exp=4", rx_data.size()); end
    repeat (3) @(negedge clk);
    total++; if (rx_data.size() !== 4) begin bad++; $display("FAIL basic_count got=%0d exp=4", rx_data.size()); end
    for (int i = 0; i < rx_data.size() && i < 4; i++) begin
      total++;
      if (rx_data[i] !== pat(16'(i)) || rx_resp[i] !== 2'b00 || rx_last[i] !== (i == 3)) begin
        bad++; $display("FAIL basic_beat%0d got=%h/%b/%b exp=%h/00/%b", i, rx_data[i][31:0], rx_resp[i], rx_last[i], pat(16'(i)) & 512'hFFFFFFFF, (i == 3));
      end
    end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL basic_idle got=%0b exp=1", idle); end
  endtask

  task automatic test_backpressure();
    bit ok; int base_cnt; int p;
    clear_rx(); r_ready = 1'b0; stall_err = 0; base_cnt = mem_en_cnt;
    send_ar(32'h1000, 8'd7, 2'b01, 3'd6, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_ar_accept got=0 exp=1"); end
    p = 0;
    for (int i = 0; i < 200 && rx_data.size() < 8; i++) begin
      r_ready = (p % 4 == 0) || (p % 4 == 3);
      p++;
      @(negedge clk);
    end
    r_ready = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (rx_data.size() !== 8) begin bad++; $display("FAIL bp_count got=%0d exp=8", rx_data.size()); end
    for (int i = 0; i < rx_data.size() && i < 8; i++) begin
      total++;
      if (rx_data[i] !== pat(16'(64 + i)) || rx_resp[i] !== 2'b00 || rx_last[i] !== (i == 7)) begin
        bad++; $display("FAIL bp_beat%0d got=%h/%b/%b exp_word=%0d last=%b", i, rx_data[i][31:0], rx_resp[i], rx_last[i], 64 + i, (i == 7));
      end
    end
    total++; if (stall_err !== 0) begin bad++; $display("FAIL bp_stable got=%0d exp=0", stall_err); end
    total++; if (mem_en_cnt - base_cnt !== 8) begin bad++; $display("FAIL bp_mem_reads got=%0d exp=8", mem_en_cnt - base_cnt); end
  endtask

  task automatic test_queueing();
    bit ok; int exp_w[$]; bit exp_l[$];
    int words[5] = '{200, 300, 400, 500, 600};
    int lens[5]  = '{0, 1, 2, 3, 0};
    clear_rx(); r_ready = 1'b0;
    // A stalled leading burst holds the FSM so queued requests stay in the FIFO.
    send_ar(32'(100 * 64), 8'd3, 2'b01, 3'd6, ok);
    repeat (6) @(negedge clk);
    total++; if (idle !== 1'b0) begin bad++; $display("FAIL q_busy got=%0b exp=0", idle); end
    for (int i = 0; i < 4; i++) begin
      send_ar(32'(words[i] * 64), 8'(lens[i]), 2'b01, 3'd6, ok);
      total++; if (!ok) begin bad++; $display("FAIL q_accept%0d got=0 exp=1", i); end
    end
    total++; if (ar_ready !== 1'b0) begin bad++; $display("FAIL q_full_ready got=%0b exp=0", ar_ready); end
    r_ready = 1'b1;
    send_ar(32'(words[4] * 64), 8'(lens[4]), 2'b01, 3'd6, ok);
    total++; if (!ok) begin bad++; $display("FAIL q_accept4 got=0 exp=1"); end
    for (int j = 0; j < 4; j++) begin exp_w.push_back(100 + j); exp_l.push_back(j == 3); end
    for (int i = 0; i < 5; i++)
      for (int j = 0; j <= lens[i]; j++) begin exp_w.push_back(words[i] + j); exp_l.push_back(j == lens[i]); end
    wait_beats(15, 100, ok);
    repeat (3) @(negedge clk);
    total++; if (rx_data.size() !== 15) begin bad++; $display("FAIL q_count got=%0d exp=15", rx_data.size()); end
    for (int i = 0; i < rx_data.size() && i < 15; i++) begin
      total++;
      if (rx_data[i] !== pat(16'(exp_w[i])) || rx_resp[i] !== 2'b00 || rx_last[i] !== exp_l[i]) begin
        bad++; $display("FAIL q_beat%0d got=%h/%b/%b exp_word=%0d last=%b", i, rx_data[i][31:0], rx_resp[i], rx_last[i], exp_w[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_errors();
    bit ok; int base_cnt;
    logic [1:0] bursts[3] = '{2'b10, 2'b01, 2'b01};
    logic [31:0] addrs[3] = '{32'h0, 32'(65535 * 64), 32'h40};
    logic [2:0] sizes[3]  = '{3'd6, 3'd6, 3'd5};
    int lens[3]           = '{2, 1, 0};
    r_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      clear_rx(); base_cnt = mem_en_cnt;
      send_ar(addrs[t], 8'(lens[t]), bursts[t], sizes[t], ok);
      wait_beats(lens[t] + 1, 50, ok);
      repeat (4) @(negedge clk);
      total++; if (rx_data.size() !== lens[t] + 1) begin bad++; $display("FAIL err%0d_count got=%0d exp=%0d", t, rx_data.size(), lens[t] + 1); end
      for (int i = 0; i < rx_data.size() && i <= lens[t]; i++) begin
        total++;
        if (rx_data[i] !== '0 || rx_resp[i] !== 2'b10 || rx_last[i] !== (i == lens[t])) begin
          bad++; $display("FAIL err%0d_beat%0d got=%h/%b/%b exp=0/10/%b", t, i, rx_data[i][31:0], rx_resp[i], rx_last[i], (i == lens[t]));
        end
      end
      total++; if (mem_en_cnt !== base_cnt) begin bad++; $display("FAIL err%0d_mem_reads got=%0d exp=0", t, mem_en_cnt - base_cnt); end
    end
  endtask

  task automatic test_boundary();
    bit ok;
    clear_rx(); r_ready = 1'b1;
    send_ar(32'(65532 * 64), 8'd3, 2'b01, 3'd6, ok);
    send_ar(32'(65535 * 64 + 7), 8'd0, 2'b01, 3'd6, ok);
    wait_beats(5, 50, ok);
    repeat (3) @(negedge clk);
    total++; if (rx_data.size() !== 5) begin bad++; $display("FAIL bnd_count got=%0d exp=5", rx_data.size()); end
    for (int i = 0; i < rx_data.size() && i < 5; i++) begin
      total++;
      if (rx_data[i] !== pat(16'(i < 4 ? 65532 + i : 65535)) || rx_resp[i] !== 2'b00 || rx_last[i] !== (i >= 3)) begin
        bad++; $display("FAIL bnd_beat%0d got=%h/%b/%b exp_word=%0d", i, rx_data[i][31:0], rx_resp[i], rx_last[i], (i < 4 ? 65532 + i : 65535));
      end
    end
  endtask

  task automatic test_reset_midburst();
    bit ok; int n_after;
    clear_rx(); r_ready = 1'b1;
    send_ar(32'(10 * 64), 8'd7, 2'b01, 3'd6, ok);
    wait_beats(2, 50, ok);
    total++; if (!ok) begin bad++; $display("FAIL rst_mid_reach got=%0d beats exp=2", rx_data.size()); end
    reset = 1'b1;
    @(negedge clk);
    total++; if (r_valid !== 1'b0 || idle !== 1'b1) begin bad++; $display("FAIL rst_mid_state got=valid%0b idle%0b exp=valid0 idle1", r_valid, idle); end
    reset = 1'b0;
    n_after = rx_data.size();
    repeat (8) @(negedge clk);
    total++; if (rx_data.size() !== n_after) begin bad++; $display("FAIL rst_mid_stale got=%0d exp=%0d", rx_data.size(), n_after); end
    clear_rx();
    send_ar(32'(20 * 64), 8'd1, 2'b01, 3'd6, ok);
    wait_beats(2, 50, ok);
    repeat (4) @(negedge clk);
    total++; if (rx_data.size() !== 2) begin bad++; $display("FAIL rst_new_count got=%0d exp=2", rx_data.size()); end
    for (int i = 0; i < rx_data.size() && i < 2; i++) begin
      total++;
      if (rx_data[i] !== pat(16'(20 + i)) || rx_resp[i] !== 2'b00 || rx_last[i] !== (i == 1)) begin
        bad++; $display("FAIL rst_new_beat%0d got=%h/%b/%b exp_word=%0d", i, rx_data[i][31:0], rx_resp[i], rx_last[i], 20 + i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_queueing();
    test_errors();
    test_boundary();
    test_reset_midburst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ref_pix_axi_rd_slave.md
Name: ref_pix_axi_rd_slave

Overview:
- Synthesizable AXI4 read-only responder that serves the inter-prediction reference cache's AR/R read-master port from an on-chip reference-pixel memory.
- Replaces the behavioural DDR model for FPGA bring-up.
- Queues read-address requests, generates INCR bursts against a 1-cycle-latency block-RAM read port, honours R-channel backpressure, and flags illegal requests with SLVERR.

Parameters:
- AXI_ADDR_WDTH, 32, AXI byte-address width.
- AXI_CACHE_DATA_WDTH, 512, R data width; DATA_BYTES = AXI_CACHE_DATA_WDTH/8, must be a power of 2.
- MEM_ADDR_WDTH, 16, word-address width of the backing memory (2^MEM_ADDR_WDTH words of AXI_CACHE_DATA_WDTH).
- MEM_BASE_ADDR, 0, AXI byte address mapped to memory word 0.
- AR_FIFO_DEPTH, 4, outstanding read-address entries (power of 2, >=2).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ref_pix_axi_ar_addr  in  AXI_ADDR_WDTH  burst start byte address.
- ref_pix_axi_ar_len  in  8  beats minus 1.
- ref_pix_axi_ar_size  in  3  bytes per beat, log2 encoded.
- ref_pix_axi_ar_burst  in  2  burst type.
- ref_pix_axi_ar_prot  in  3  ignored.
- ref_pix_axi_ar_valid  in  1  AR valid.
- ref_pix_axi_ar_ready  out  1  AR ready.
- ref_pix_axi_r_data  out  AXI_CACHE_DATA_WDTH  read data.
- ref_pix_axi_r_resp  out  2  00 OKAY, 10 SLVERR.
- ref_pix_axi_r_last  out  1  final beat of burst.
- ref_pix_axi_r_valid  out  1  R valid.
- ref_pix_axi_r_ready  in  1  R ready.
- mem_rd_en_out  out  1  memory read strobe.
- mem_rd_addr_out  out  MEM_ADDR_WDTH  memory word address.
- mem_rd_data_in  in  AXI_CACHE_DATA_WDTH  read data, valid the cycle after mem_rd_en_out.
- rd_slave_idle_out  out  1  AR FIFO empty, no burst active, R buffer empty.

Behaviour:
- Reset values: ar_ready=0 during reset and 1 the first cycle after. r_valid=0, r_last=0, r_resp=00, r_data=0, mem_rd_en_out=0, mem_rd_addr_out=0, rd_slave_idle_out=1. AR FIFO, read-credit counter and all state are cleared.
- Reset asserted mid-burst aborts the burst. No further R beats are produced, and any in-flight memory data is discarded.
- AR channel: ar_ready = FIFO not full. A request is accepted on ar_valid & ar_ready and stores {addr, len, err}.
  - err is set if ar_burst != 01 (INCR).
  - err is set if ar_size != log2(DATA_BYTES).
  - err is set if ar_addr < MEM_BASE_ADDR.
  - err is set if word index + len > 2^MEM_ADDR_WDTH - 1.
- Word index = (ar_addr - MEM_BASE_ADDR) >> log2(DATA_BYTES). Low address bits are ignored, so unaligned addresses align down.
- A push and a pop in the same cycle on a full FIFO is legal only for the pop. ar_ready stays 0 that cycle.
- FSM IDLE:
  - When the FIFO is non-empty, pop the head.
  - Load word pointer = index and beat counter = len.
  - Latch err, then go to BURST.
- FSM BURST, each cycle a read credit is available:
  - Issue one beat. For a non-err burst this asserts mem_rd_en_out at the pointer; for an err burst it injects a zero-data SLVERR beat with no memory access.
  - Increment the pointer and decrement the counter.
  - On the beat with counter==0, mark it last and return to IDLE.
  - From IDLE, the next burst may pop on the following cycle.
- Output buffer: a 2-entry skid FIFO of {data, resp, last}. The head drives the R outputs, and r_valid = buffer not empty.
  - Credit counter = buffer occupancy + issued beats still in flight.
  - A beat issues only when credit < 2, so no data is ever lost under backpressure.
- R data is stable while r_valid & !r_ready. The head pops on r_valid & r_ready.
- Latency and throughput:
  - AR handshake at cycle T. Pop at T+1, mem read at T+2, first r_valid at T+3.
  - Sustained throughput is 1 beat/cycle with r_ready held high.
  - Bursts are returned in AR acceptance order, with no interleaving.
- An err burst still returns exactly len+1 beats, all r_resp=10 and r_data=0, with r_last on the final beat.
- len=0 gives a single beat with r_last=1.
- A burst may end exactly at word 2^MEM_ADDR_WDTH-1 and is legal; the word pointer never wraps inside a legal burst.

Test Plan:
- Basic: with reset released, AR addr 0x0, len 3, size 6, burst 01, r_ready=1 -> 4 beats carrying memory words 0..3, resp 00, r_last on beat 4, first r_valid 3 cycles after the AR handshake.
- Backpressure: AR addr 0x1000, len 7; r_ready toggles 1,0,0,1 repeating -> words 64..71 are delivered in order with none dropped or duplicated, r_data is stable while stalled, and credit never exceeds 2.
- Queueing: 5 back-to-back ARs (len 0,1,2,3,0) while r_ready=0 -> ar_ready deasserts after 4 accepts. On r_ready=1, all 11 beats return in request order with r_last after beats 1,3,6,10,11.
- Errors: AR burst 10 with len 2 -> 3 beats with resp 10, data 0, last on beat 3, mem_rd_en_out never asserted. Separately, AR addr at word 65535 with len 1 -> 2 SLVERR beats.
- Boundary: AR at word 65532, len 3 -> OKAY, words 65532..65535 returned.
- Reset mid-burst: assert reset on beat 2 of a len-7 burst -> the next cycle r_valid=0 and idle=1. A new AR after reset returns correct data with no stale beats.
